// File: rtl/digitos_a_binario.sv
// ---------------------------------------------------------------------------
// digitos_a_binario
//
// Converts six latched BCD digits into a 20-bit binary value by serial
// Horner evaluation: the accumulator absorbs one digit per clock, starting
// with the most significant digit, so a conversion takes exactly six
// cycles from the accepted start edge to the done pulse.
//
// Ports
//   clk        : single clock, all state updates on its rising edge
//   rst        : synchronous active-high reset, has priority over start
//   start      : conversion request, only honoured while idle
//   d0..d5     : BCD digits, d0 = units, d5 = hundred-thousands
//   resultado  : binary value of the last completed conversion
//                (0 when that conversion held a non-BCD digit)
//   busy       : high while a conversion is in progress
//   done       : one-cycle pulse when resultado and error are updated
//   error      : last conversion contained a digit above 9; held until
//                the next accepted start
// ---------------------------------------------------------------------------
module digitos_a_binario #(
    parameter int NDIG = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  d0,
    input  logic [3:0]  d1,
    input  logic [3:0]  d2,
    input  logic [3:0]  d3,
    input  logic [3:0]  d4,
    input  logic [3:0]  d5,
    output logic [19:0] resultado,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int RES_W = 20;
    localparam logic [2:0] IDX_TOP = 3'd5;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t                 state, state_n;
    logic [NDIG-1:0][3:0]   dig, dig_n;
    logic [RES_W-1:0]       acc, acc_n;
    logic [RES_W-1:0]       acc_step;
    logic [2:0]             idx, idx_n;
    logic [RES_W-1:0]       resultado_n;
    logic                   busy_n;
    logic                   done_n;
    logic                   error_n;

    // acc*10 + digit built from two shifts and an add; wraps at 20 bits,
    // which is harmless because 999999 is the largest legal result and any
    // illegal digit forces the published result to zero anyway.
    function automatic logic [RES_W-1:0] mac10(input logic [RES_W-1:0] a,
                                               input logic [3:0]       digit);
        logic [RES_W-1:0] x8;
        logic [RES_W-1:0] x2;
        x8 = a << 3;
        x2 = a << 1;
        return x8 + x2 + {{(RES_W-4){1'b0}}, digit};
    endfunction

    function automatic logic has_invalid(input logic [NDIG-1:0][3:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (v[i] > 4'd9) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

    assign acc_step = mac10(acc, dig[idx]);

    always_comb begin
        state_n     = state;
        dig_n       = dig;
        acc_n       = acc;
        idx_n       = idx;
        resultado_n = resultado;
        busy_n      = busy;
        done_n      = 1'b0;
        error_n     = error;

        case (state)
            IDLE: begin
                if (start) begin
                    dig_n   = {d5, d4, d3, d2, d1, d0};
                    acc_n   = '0;
                    idx_n   = IDX_TOP;
                    busy_n  = 1'b1;
                    error_n = 1'b0;
                    state_n = CONV;
                end
            end

            CONV: begin
                // start is deliberately not looked at here: requests during
                // a conversion are dropped, not queued.
                acc_n = acc_step;
                idx_n = idx - 3'd1;
                if (idx == 3'd0) begin
                    idx_n   = 3'd0;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    state_n = IDLE;
                    if (has_invalid(dig)) begin
                        resultado_n = '0;
                        error_n     = 1'b1;
                    end else begin
                        resultado_n = acc_step;
                    end
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            idx       <= 3'd0;
            resultado <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            state     <= state_n;
            acc       <= acc_n;
            idx       <= idx_n;
            resultado <= resultado_n;
            busy      <= busy_n;
            done      <= done_n;
            error     <= error_n;
        end
    end

    // Latched digits are pure data: they are only consumed in CONV, which
    // always follows a load, so they need no reset.
    always_ff @(posedge clk) begin
        dig <= dig_n;
    end

endmodule

// File: tb/tb_digitos_a_binario.sv
module tb_digitos_a_binario;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  d0, d1, d2, d3, d4, d5;
    logic [19:0] resultado;
    logic        busy;
    logic        done;
    logic        error;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        logic [19:0] res;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t q[$];

    digitos_a_binario #(.NDIG(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .d0        (d0),
        .d1        (d1),
        .d2        (d2),
        .d3        (d3),
        .d4        (d4),
        .d5        (d5),
        .resultado (resultado),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Digits given as {d5,d4,d3,d2,d1,d0}; BCD reads directly as hex.
    task automatic set_digits(input logic [23:0] v);
        {d5, d4, d3, d2, d1, d0} = v;
    endtask

    // Single start pulse, checks busy over the six conversion cycles and
    // leaves the caller in the done cycle.
    task automatic run(input logic [23:0] dg, input logic [19:0] exp_res, input logic exp_err);
        exp_t e;
        set_digits(dg);
        start = 1'b1;
        e.res = exp_res;
        e.err = exp_err;
        e.cyc = cyc + 7;
        q.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        chk("error_clear_at_start", {31'd0, error}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            chk("busy_during_conv", {31'd0, busy}, 32'd1);
            @(posedge clk); #1;
        end
        chk("busy_after_conv", {31'd0, busy}, 32'd0);
    endtask

    // Scoreboard monitor: done pops the next expectation; an overdue
    // expectation without done counts as a miss.
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1 resultado=%0h, required no done (cycle %0d)",
                         resultado, cyc);
            end else begin
                e = q.pop_front();
                chk("resultado", {12'd0, resultado}, {12'd0, e.res});
                chk("error", {31'd0, error}, {31'd0, e.err});
                chk("done_cycle", cyc, e.cyc);
            end
        end else if (q.size() > 0 && cyc > q[0].cyc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL missing_done: got no done by cycle %0d, required done at cycle %0d",
                     cyc, q[0].cyc);
            void'(q.pop_front());
        end
    end

    initial begin
        exp_t e;
        logic seen_done;
        rst   = 1'b1;
        start = 1'b0;
        set_digits(24'h000000);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_resultado", {12'd0, resultado}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_error", {31'd0, error}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Nominal, then both extremes issued back-to-back in the done cycle.
        run(24'h123456, 20'h1E240, 1'b0);
        run(24'h999999, 20'hF423F, 1'b0);
        run(24'h000000, 20'h00000, 1'b0);
        @(posedge clk); #1;

        // Invalid digit d3=B: result forced to 0, error held while idle.
        run(24'h11B111, 20'h00000, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("error_held", {31'd0, error}, 32'd1);
        chk("resultado_held", {12'd0, resultado}, 32'd0);

        // Next start clears error at its start edge (checked inside run).
        run(24'h000042, 20'h0002A, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        // start re-asserted at N+2 and digits changed at N+3: ignored.
        set_digits(24'h654321);
        start = 1'b1;
        e.res = 20'h9FBF1;
        e.err = 1'b0;
        e.cyc = cyc + 7;
        q.push_back(e);
        @(posedge clk); #1;            // after edge N
        start = 1'b0;
        @(posedge clk); #1;            // after edge N+1
        start = 1'b1;
        @(posedge clk); #1;            // after edge N+2
        start = 1'b0;
        set_digits(24'h999999);
        repeat (6) @(posedge clk);
        #1;

        // start held through the done cycle: second conversion accepted
        // at the edge that closes the done cycle, done 7 cycles after the first.
        set_digits(24'h111111);
        start = 1'b1;
        e.res = 20'h1B207;
        e.err = 1'b0;
        e.cyc = cyc + 7;
        q.push_back(e);
        e.res = 20'h3640E;
        e.cyc = cyc + 14;
        q.push_back(e);
        @(posedge clk); #1;            // after edge N
        set_digits(24'h222222);
        repeat (7) @(posedge clk);
        #1;                            // after edge N+7, second start taken
        start = 1'b0;
        set_digits(24'h000000);
        repeat (8) @(posedge clk);
        #1;

        // Reset at N+3 aborts without done; previous result was non-zero.
        set_digits(24'h123456);
        start = 1'b1;
        @(posedge clk); #1;            // after edge N
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;            // after edge N+2
        rst = 1'b1;
        @(posedge clk); #1;            // after edge N+3
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_resultado", {12'd0, resultado}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen_done = 1'b1;
        end
        chk("no_done_after_abort", {31'd0, seen_done}, 32'd0);

        // First start after reset converts normally.
        run(24'h654321, 20'h9FBF1, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_drained", q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
